// File: rtl/fmul_seq.sv
// ---------------------------------------------------------------------------
// fmul_seq -- iterative FP32 multiplier (shift-add, RADIX_BITS bits per cycle)
//
// Operands arrive unpacked (sign, biased exp, 23-bit fraction). The result
// leaves unpacked as sign, biased exp and {1'b0, 23-bit fraction} for the
// pack/writeback stage. Denormal operands are flushed to zero.
//
// Build option:
//   FMUL_ROUND_RNE_EN  defined   -> round-to-nearest-even in NORM
//                      undefined -> truncate (default)
//   Latency is the same in both builds.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    operand handshake; in_ready is high only in IDLE
//   A_sign/A_exp/A_frac    operand A
//   B_sign/B_exp/B_frac    operand B
//   out_valid / out_ready  result handshake; result held until accepted
//   sign, exp, frac        result fields
//   error                  invalid operation (NaN result)
//   overflow               result is +/-inf
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high; the sender keeps valid and data stable
// until that edge.
//
// FSM: IDLE -> MUL (N = 24/RADIX_BITS cycles) -> NORM -> DONE -> IDLE.
//      Special operands go straight IDLE -> DONE.
// ---------------------------------------------------------------------------
module fmul_seq #(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        A_sign,
    input  logic [7:0]  A_exp,
    input  logic [22:0] A_frac,
    input  logic        B_sign,
    input  logic [7:0]  B_exp,
    input  logic [22:0] B_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] frac,
    output logic        error,
    output logic        overflow
);

    localparam int N = 24 / RADIX_BITS;
    localparam logic [4:0] LAST_CNT = 5'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [47:0] mcand_q, mcand_d;     // {1,A_frac}, shifted left each MUL cycle
    logic [23:0] mplier_q, mplier_d;   // {1,B_frac}, shifted right each MUL cycle
    logic [47:0] acc_q, acc_d;
    logic [7:0]  a_exp_q, a_exp_d;
    logic [7:0]  b_exp_q, b_exp_d;
    logic        op_sign_q, op_sign_d;

    logic        sign_q, sign_d;
    logic [7:0]  exp_q, exp_d;
    logic [23:0] frac_q, frac_d;
    logic        error_q, error_d;
    logic        overflow_q, overflow_d;

    // ---------------- operand classification (on the input bus) -------------
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic cls_invalid, cls_inf, cls_zero;

    always_comb begin
        a_zero = (A_exp == 8'h00);
        b_zero = (B_exp == 8'h00);
        a_inf  = (A_exp == 8'hff) && (A_frac == 23'h0);
        b_inf  = (B_exp == 8'hff) && (B_frac == 23'h0);
        a_nan  = (A_exp == 8'hff) && (A_frac != 23'h0);
        b_nan  = (B_exp == 8'hff) && (B_frac != 23'h0);
        cls_invalid = a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero);
        cls_inf     = a_inf | b_inf;
        cls_zero    = a_zero | b_zero;
    end

    // ---------------- one shift-add step -------------------------------------
    logic [47:0] partial;
    always_comb begin
        partial = mcand_q * {{(48 - RADIX_BITS){1'b0}}, mplier_q[RADIX_BITS-1:0]};
    end

    // ---------------- normalisation / rounding -------------------------------
    logic [22:0] norm_f;
    logic        guard_bit, sticky_bit, e_inc;
    logic [23:0] f_rnd;      // bit 23 is the mantissa carry-out of rounding
    logic [9:0]  e_norm;     // signed exponent after normalisation/rounding

    always_comb begin
        if (acc_q[47]) begin
            norm_f     = acc_q[46:24];
            guard_bit  = acc_q[23];
            sticky_bit = |acc_q[22:0];
            e_inc      = 1'b1;
        end else begin
            norm_f     = acc_q[45:23];
            guard_bit  = acc_q[22];
            sticky_bit = |acc_q[21:0];
            e_inc      = 1'b0;
        end
        e_norm = {2'b00, a_exp_q} + {2'b00, b_exp_q} - 10'd127 + {9'd0, e_inc};
`ifdef FMUL_ROUND_RNE_EN
        f_rnd = {1'b0, norm_f} + {23'd0, guard_bit & (sticky_bit | norm_f[0])};
        // Carry-out leaves f_rnd[22:0] == 0 and bumps the exponent.
        if (f_rnd[23]) begin
            e_norm = e_norm + 10'd1;
        end
`else
        f_rnd = {1'b0, norm_f};
`endif
    end

`ifndef FMUL_ROUND_RNE_EN
    // Guard/sticky only feed the rounding build.
    logic unused_round_bits;
    assign unused_round_bits = guard_bit ^ sticky_bit ^ f_rnd[23];
`endif

    // ---------------- next-state logic ---------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        a_exp_d    = a_exp_q;
        b_exp_d    = b_exp_q;
        op_sign_d  = op_sign_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        frac_d     = frac_q;
        error_d    = error_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_sign_d = A_sign ^ B_sign;
                    a_exp_d   = A_exp;
                    b_exp_d   = B_exp;
                    mcand_d   = {24'd0, 1'b1, A_frac};
                    mplier_d  = {1'b1, B_frac};
                    acc_d     = 48'd0;
                    cnt_d     = 5'd0;
                    if (cls_invalid || cls_inf || cls_zero) begin
                        // Specials bypass the datapath entirely.
                        state_d    = S_DONE;
                        sign_d     = A_sign ^ B_sign;
                        error_d    = cls_invalid;
                        overflow_d = ~cls_invalid & cls_inf;
                        if (cls_invalid) begin
                            exp_d  = 8'hff;
                            frac_d = 24'h000011;
                        end else if (cls_inf) begin
                            exp_d  = 8'hff;
                            frac_d = 24'h0;
                        end else begin
                            exp_d  = 8'h00;
                            frac_d = 24'h0;
                        end
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end

            S_MUL: begin
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << RADIX_BITS;
                mplier_d = mplier_q >> RADIX_BITS;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
                state_d = S_DONE;
                sign_d  = op_sign_q;
                error_d = 1'b0;
                if ($signed(e_norm) >= $signed(10'd255)) begin
                    overflow_d = 1'b1;
                    exp_d      = 8'hff;
                    frac_d     = 24'h0;
                end else if ($signed(e_norm) <= $signed(10'd0)) begin
                    overflow_d = 1'b0;
                    exp_d      = 8'h00;
                    frac_d     = 24'h0;
                end else begin
                    overflow_d = 1'b0;
                    exp_d      = e_norm[7:0];
                    frac_d     = {1'b0, f_rnd[22:0]};
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- registers ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            mcand_q    <= 48'd0;
            mplier_q   <= 24'd0;
            acc_q      <= 48'd0;
            a_exp_q    <= 8'd0;
            b_exp_q    <= 8'd0;
            op_sign_q  <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= 8'd0;
            frac_q     <= 24'd0;
            error_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            a_exp_q    <= a_exp_d;
            b_exp_q    <= b_exp_d;
            op_sign_q  <= op_sign_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            frac_q     <= frac_d;
            error_q    <= error_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- outputs ------------------------------------------------
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sign      = sign_q;
    assign exp       = exp_q;
    assign frac      = frac_q;
    assign error     = error_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fmul_seq.sv
// ---------------------------------------------------------------------------
// tb_fmul_seq -- directed bench for fmul_seq (RADIX_BITS = 1, N = 24).
// Expected values are hand-computed products of the stimulus operands.
// ---------------------------------------------------------------------------
module tb_fmul_seq;

    localparam int RADIX_BITS = 1;
    localparam int N          = 24 / RADIX_BITS;
    localparam int LAT_NORMAL = N + 1;   // edges after the accept edge
    localparam int LAT_SPEC   = 0;       // specials are in DONE right after the accept edge
    localparam int LAT_LIMIT  = 60;

`ifdef FMUL_ROUND_RNE_EN
    localparam logic [23:0] F_RND_CASE = 24'h400002;
`else
    localparam logic [23:0] F_RND_CASE = 24'h400001;
`endif

    // ---------------- clock / reset ------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        A_sign, B_sign;
    logic [7:0]  A_exp, B_exp;
    logic [22:0] A_frac, B_frac;
    logic        out_valid, out_ready;
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] frac;
    logic        error, overflow;

    always #5 clk = ~clk;

    fmul_seq #(.RADIX_BITS(RADIX_BITS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_sign(A_sign), .A_exp(A_exp), .A_frac(A_frac),
        .B_sign(B_sign), .B_exp(B_exp), .B_frac(B_frac),
        .out_valid(out_valid), .out_ready(out_ready),
        .sign(sign), .exp(exp), .frac(frac),
        .error(error), .overflow(overflow)
    );

    // ---------------- scoreboard ---------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, want);
        end
    endtask

    // ---------------- driver -------------------------------------------------
    // Runs one operation, checks latency and result; hold > 0 keeps
    // out_ready low for that many cycles in DONE.
    task automatic run_op(input string tag,
                          input logic as_, input logic [7:0] ae, input logic [22:0] af,
                          input logic bs_, input logic [7:0] be, input logic [22:0] bf,
                          input logic ws, input logic [7:0] we, input logic [23:0] wf,
                          input logic werr, input logic wovf, input int wlat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        A_sign = as_; A_exp = ae; A_frac = af;
        B_sign = bs_; B_exp = be; B_frac = bf;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        // Scramble operands after the accept edge; they must have been captured.
        in_valid = 1'b0;
        A_sign = ~as_; A_exp = ~ae; A_frac = ~af;
        B_sign = ~bs_; B_exp = ~be; B_frac = ~bf;
        lat = 0;
        while (!out_valid && lat < LAT_LIMIT) begin
            if (lat == 10) check({tag, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, wlat);
        check({tag, "_sign"},    {31'd0, sign}, {31'd0, ws});
        check({tag, "_exp"},     {24'd0, exp},  {24'd0, we});
        check({tag, "_frac"},    {8'd0, frac},  {8'd0, wf});
        check({tag, "_error"},   {31'd0, error}, {31'd0, werr});
        check({tag, "_overflow"},{31'd0, overflow}, {31'd0, wovf});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_hold_exp"}, {24'd0, exp}, {24'd0, we});
            check({tag, "_hold_frac"}, {8'd0, frac}, {8'd0, wf});
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_released_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_released_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // ---------------- stimulus -----------------------------------------------
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A_sign = 1'b0; A_exp = 8'd0; A_frac = 23'd0;
        B_sign = 1'b0; B_exp = 8'd0; B_frac = 23'd0;
        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    {sign, exp, frac[22:0]}, 32'd0);
        check("rst_flags",     {30'd0, error, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 x 2.0 = 3.0
        run_op("mul_1p5_x_2", 0, 8'd127, 23'h400000, 0, 8'd128, 23'h0,
               0, 8'd128, 24'h400000, 0, 0, LAT_NORMAL, 0);
        // 1.5 x 1.5 = 2.25: product MSB set, exponent bump
        run_op("mul_1p5_sq", 0, 8'd127, 23'h400000, 1, 8'd127, 23'h400000,
               1, 8'd128, 24'h100000, 0, 0, LAT_NORMAL, 0);
        // 1.5 x (1 + 2^-23): guard=1, f[0]=1 -> rounds up under RNE
        run_op("mul_round", 0, 8'd127, 23'h400000, 0, 8'd127, 23'h000001,
               0, 8'd127, F_RND_CASE, 0, 0, LAT_NORMAL, 0);
        // zero x inf -> invalid
        run_op("zero_x_inf", 0, 8'd0, 23'h0, 0, 8'hff, 23'h0,
               0, 8'hff, 24'h000011, 1, 0, LAT_SPEC, 0);
        // NaN x 1.0 -> invalid, sign still xor
        run_op("nan_x_one", 0, 8'hff, 23'h000005, 1, 8'd127, 23'h0,
               1, 8'hff, 24'h000011, 1, 0, LAT_SPEC, 0);
        // -inf x -2.0 -> +inf
        run_op("inf_x_two", 1, 8'hff, 23'h0, 1, 8'd128, 23'h0,
               0, 8'hff, 24'h0, 0, 1, LAT_SPEC, 0);
        // -denormal x finite -> -0
        run_op("denorm_x_fin", 1, 8'd0, 23'h00007b, 0, 8'd130, 23'h000005,
               1, 8'd0, 24'h0, 0, 0, LAT_SPEC, 0);
        // exponent overflow: 254 + 254 - 127
        run_op("exp_ovf", 1, 8'd254, 23'h0, 0, 8'd254, 23'h0,
               1, 8'hff, 24'h0, 0, 1, LAT_NORMAL, 0);
        // exponent boundary: e = 255 exactly overflows
        run_op("exp_255", 0, 8'd191, 23'h0, 0, 8'd191, 23'h0,
               0, 8'hff, 24'h0, 0, 1, LAT_NORMAL, 0);
        // exponent boundary: e = 254 is still finite
        run_op("exp_254", 0, 8'd190, 23'h0, 0, 8'd191, 23'h0,
               0, 8'd254, 24'h0, 0, 0, LAT_NORMAL, 0);
        // exponent underflow: 1 + 1 - 127
        run_op("exp_unf", 1, 8'd1, 23'h0, 0, 8'd1, 23'h0,
               1, 8'd0, 24'h0, 0, 0, LAT_NORMAL, 0);
        // exponent boundary: e = 0 flushes, e = 1 survives
        run_op("exp_0", 0, 8'd64, 23'h0, 0, 8'd63, 23'h0,
               0, 8'd0, 24'h0, 0, 0, LAT_NORMAL, 0);
        run_op("exp_1", 0, 8'd64, 23'h0, 0, 8'd64, 23'h0,
               0, 8'd1, 24'h0, 0, 0, LAT_NORMAL, 0);
        // back-pressure: result held 5 cycles in DONE
        run_op("hold", 0, 8'd127, 23'h400000, 0, 8'd128, 23'h0,
               0, 8'd128, 24'h400000, 0, 0, LAT_NORMAL, 5);

        // Reset during MUL cycle 10 discards the operation.
        @(negedge clk);
        A_sign = 1'b1; A_exp = 8'd254; A_frac = 23'h7fffff;
        B_sign = 1'b0; B_exp = 8'd254; B_frac = 23'h7fffff;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_result",    {sign, exp, frac[22:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_abort", 0, 8'd127, 23'h400000, 0, 8'd128, 23'h0,
               0, 8'd128, 24'h400000, 0, 0, LAT_NORMAL, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
